// File: rtl/cache_pkg.sv
// Shared cache types: controller state encoding and CPU request type.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        WRITEBACK,
        FETCH
    } cache_ctrl_state_t;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } cache_op_t;

endpackage : cache_pkg

// File: rtl/cache_internal_if.sv
// Control bundle between the cache controller FSM and the cache datapath.
interface cache_internal_if;

    logic process_lru_counters;
    logic perform_write;
    logic set_selected_dirty_bit;
    logic clear_selected_dirty_bit;
    logic clear_selected_valid_bit;
    logic set_hmem_block_address;
    logic use_victim_tag_for_hmem_block_address;
    logic reset_counter;
    logic decrement_counter;
    logic miss_recovery_mode;
    logic finish_new_line_install;
    logic count_hit;
    logic count_miss;
    logic count_read;
    logic count_write;

    logic counter_done;
    logic valid_block_match;
    logic valid_dirty_bit;

    modport controller (
        output process_lru_counters,
        output perform_write,
        output set_selected_dirty_bit,
        output clear_selected_dirty_bit,
        output clear_selected_valid_bit,
        output set_hmem_block_address,
        output use_victim_tag_for_hmem_block_address,
        output reset_counter,
        output decrement_counter,
        output miss_recovery_mode,
        output finish_new_line_install,
        output count_hit,
        output count_miss,
        output count_read,
        output count_write,
        input  counter_done,
        input  valid_block_match,
        input  valid_dirty_bit
    );

    modport datapath (
        input  process_lru_counters,
        input  perform_write,
        input  set_selected_dirty_bit,
        input  clear_selected_dirty_bit,
        input  clear_selected_valid_bit,
        input  set_hmem_block_address,
        input  use_victim_tag_for_hmem_block_address,
        input  reset_counter,
        input  decrement_counter,
        input  miss_recovery_mode,
        input  finish_new_line_install,
        input  count_hit,
        input  count_miss,
        input  count_read,
        input  count_write,
        output counter_done,
        output valid_block_match,
        output valid_dirty_bit
    );

endinterface : cache_internal_if

// File: rtl/cache_controller.sv
// Cache control FSM: lookup, hit service, dirty-victim writeback and line fill,
// one CPU request at a time, word-by-word transfers to hmem.
module cache_controller
    import cache_pkg::*;
#(
    parameter int unsigned ENABLE_STATS = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    cache_internal_if.controller         ctrl,
    input  logic                         req_valid,
    input  logic                         req_op,
    output logic                         req_ready,
    output logic                         req_done,
    output logic                         hmem_req_valid,
    output logic                         hmem_req_write,
    input  logic                         hmem_req_ack
);

    localparam bit STATS_ON = (ENABLE_STATS != 0);

    cache_ctrl_state_t state_q, state_d;
    cache_op_t         op_q, op_d;
    logic              replay_q, replay_d;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= OP_READ;
            replay_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            replay_q <= replay_d;
        end
    end

    // Next-state and control decode
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        replay_d = replay_q;

        req_ready      = 1'b0;
        req_done       = 1'b0;
        hmem_req_valid = 1'b0;
        hmem_req_write = 1'b0;

        ctrl.process_lru_counters                  = 1'b0;
        ctrl.perform_write                         = 1'b0;
        ctrl.set_selected_dirty_bit                = 1'b0;
        ctrl.clear_selected_dirty_bit              = 1'b0;
        ctrl.clear_selected_valid_bit              = 1'b0;
        ctrl.set_hmem_block_address                = 1'b0;
        ctrl.use_victim_tag_for_hmem_block_address = 1'b0;
        ctrl.reset_counter                         = 1'b0;
        ctrl.decrement_counter                     = 1'b0;
        ctrl.miss_recovery_mode                    = 1'b0;
        ctrl.finish_new_line_install               = 1'b0;
        ctrl.count_hit                             = 1'b0;
        ctrl.count_miss                            = 1'b0;
        ctrl.count_read                            = 1'b0;
        ctrl.count_write                           = 1'b0;

        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    op_d     = cache_op_t'(req_op);
                    replay_d = 1'b0;
                    state_d  = COMPARE;
                end
            end

            COMPARE: begin
                // Replay lookups after a fill are not counted a second time
                if (STATS_ON && !replay_q) begin
                    ctrl.count_hit   = ctrl.valid_block_match;
                    ctrl.count_miss  = !ctrl.valid_block_match;
                    ctrl.count_read  = (op_q == OP_READ);
                    ctrl.count_write = (op_q == OP_WRITE);
                end
                if (ctrl.valid_block_match) begin
                    ctrl.process_lru_counters   = 1'b1;
                    req_done                    = 1'b1;
                    ctrl.perform_write          = (op_q == OP_WRITE);
                    ctrl.set_selected_dirty_bit = (op_q == OP_WRITE);
                    state_d                     = IDLE;
                end else if (ctrl.valid_dirty_bit) begin
                    ctrl.set_hmem_block_address                = 1'b1;
                    ctrl.use_victim_tag_for_hmem_block_address = 1'b1;
                    ctrl.reset_counter                         = 1'b1;
                    state_d                                    = WRITEBACK;
                end else begin
                    ctrl.set_hmem_block_address   = 1'b1;
                    ctrl.reset_counter            = 1'b1;
                    ctrl.clear_selected_valid_bit = 1'b1;
                    state_d                       = FETCH;
                end
            end

            WRITEBACK: begin
                ctrl.miss_recovery_mode = 1'b1;
                hmem_req_valid          = 1'b1;
                hmem_req_write          = 1'b1;
                if (hmem_req_ack) begin
                    ctrl.decrement_counter = 1'b1;
                    // Last victim word: retarget the address at the fill tag
                    if (ctrl.counter_done) begin
                        ctrl.clear_selected_dirty_bit = 1'b1;
                        ctrl.set_hmem_block_address   = 1'b1;
                        ctrl.reset_counter            = 1'b1;
                        ctrl.clear_selected_valid_bit = 1'b1;
                        state_d                       = FETCH;
                    end
                end
            end

            FETCH: begin
                ctrl.miss_recovery_mode = 1'b1;
                hmem_req_valid          = 1'b1;
                if (hmem_req_ack) begin
                    ctrl.decrement_counter = 1'b1;
                    if (ctrl.counter_done) begin
                        ctrl.finish_new_line_install = 1'b1;
                        replay_d                     = 1'b1;
                        state_d                      = COMPARE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule : cache_controller

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: per-cycle decode vectors on two instances
// (stats on/off) plus multi-cycle miss/reset sequences against a W=4 datapath model.
module tb_cache_controller;
    import cache_pkg::*;

    localparam int unsigned W = 4;

    // Output bundle bit masks, MSB first
    localparam logic [18:0] O_RDY    = 19'h40000;
    localparam logic [18:0] O_DONE   = 19'h20000;
    localparam logic [18:0] O_HV     = 19'h10000;
    localparam logic [18:0] O_HW     = 19'h08000;
    localparam logic [18:0] O_LRU    = 19'h04000;
    localparam logic [18:0] O_PW     = 19'h02000;
    localparam logic [18:0] O_SD     = 19'h01000;
    localparam logic [18:0] O_SADDR  = 19'h00800;
    localparam logic [18:0] O_VICT   = 19'h00400;
    localparam logic [18:0] O_RCNT   = 19'h00200;
    localparam logic [18:0] O_CVAL   = 19'h00100;
    localparam logic [18:0] O_CHIT   = 19'h00080;
    localparam logic [18:0] O_CMISS  = 19'h00040;
    localparam logic [18:0] O_CREAD  = 19'h00020;
    localparam logic [18:0] O_CWRITE = 19'h00010;
    localparam logic [18:0] O_MREC   = 19'h00008;
    localparam logic [18:0] O_DEC    = 19'h00004;
    localparam logic [18:0] O_CDIRTY = 19'h00002;
    localparam logic [18:0] O_FIN    = 19'h00001;
    localparam logic [18:0] O_STATS  = O_CHIT | O_CMISS | O_CREAD | O_CWRITE;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;
    logic req_valid = 1'b0;
    logic req_op = 1'b0;
    logic hmem_req_ack = 1'b0;
    logic tbl_match = 1'b0;
    logic tbl_cdone = 1'b0;
    logic dirty_in = 1'b0;
    logic use_model = 1'b0;
    logic line_set = 1'b0;
    logic line_clear = 1'b0;

    logic rdy1, done1, hv1, hw1;
    logic rdy0, done0, hv0, hw0;

    cache_internal_if ci1();
    cache_internal_if ci0();

    // Datapath model: word counter and line-present flag
    int   cnt = 0;
    logic present = 1'b0;
    logic match, cdone;

    always @(posedge clk) begin
        if (ci1.reset_counter)
            cnt <= int'(W) - 1;
        else if (ci1.decrement_counter && cnt > 0)
            cnt <= cnt - 1;
        if (line_set)
            present <= 1'b1;
        else if (line_clear)
            present <= 1'b0;
        else if (ci1.finish_new_line_install)
            present <= 1'b1;
    end

    assign match = use_model ? present : tbl_match;
    assign cdone = use_model ? (cnt == 0) : tbl_cdone;

    assign ci1.valid_block_match = match;
    assign ci1.counter_done      = cdone;
    assign ci1.valid_dirty_bit   = dirty_in;
    assign ci0.valid_block_match = match;
    assign ci0.counter_done      = cdone;
    assign ci0.valid_dirty_bit   = dirty_in;

    cache_controller #(.ENABLE_STATS(1)) dut1 (
        .clk(clk), .reset(reset), .ctrl(ci1),
        .req_valid(req_valid), .req_op(req_op),
        .req_ready(rdy1), .req_done(done1),
        .hmem_req_valid(hv1), .hmem_req_write(hw1), .hmem_req_ack(hmem_req_ack)
    );

    cache_controller #(.ENABLE_STATS(0)) dut0 (
        .clk(clk), .reset(reset), .ctrl(ci0),
        .req_valid(req_valid), .req_op(req_op),
        .req_ready(rdy0), .req_done(done0),
        .hmem_req_valid(hv0), .hmem_req_write(hw0), .hmem_req_ack(hmem_req_ack)
    );

    logic [18:0] obs1, obs0;
    assign obs1 = {rdy1, done1, hv1, hw1, ci1.process_lru_counters, ci1.perform_write,
                   ci1.set_selected_dirty_bit, ci1.set_hmem_block_address,
                   ci1.use_victim_tag_for_hmem_block_address, ci1.reset_counter,
                   ci1.clear_selected_valid_bit, ci1.count_hit, ci1.count_miss,
                   ci1.count_read, ci1.count_write, ci1.miss_recovery_mode,
                   ci1.decrement_counter, ci1.clear_selected_dirty_bit,
                   ci1.finish_new_line_install};
    assign obs0 = {rdy0, done0, hv0, hw0, ci0.process_lru_counters, ci0.perform_write,
                   ci0.set_selected_dirty_bit, ci0.set_hmem_block_address,
                   ci0.use_victim_tag_for_hmem_block_address, ci0.reset_counter,
                   ci0.clear_selected_valid_bit, ci0.count_hit, ci0.count_miss,
                   ci0.count_read, ci0.count_write, ci0.miss_recovery_mode,
                   ci0.decrement_counter, ci0.clear_selected_dirty_bit,
                   ci0.finish_new_line_install};

    int checks = 0;
    int errors = 0;

    task automatic check_vec(input string name, input logic [18:0] got, input logic [18:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b required %b", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic        rst, vld, op, ack, mt, dty, cd;
        logic [18:0] exp;
    } vec_t;

    function automatic vec_t mk(input string n, input logic rst, input logic vld, input logic op,
                                input logic ack, input logic mt, input logic dty, input logic cd,
                                input logic [18:0] exp);
        vec_t v;
        v.name = n; v.rst = rst; v.vld = vld; v.op = op; v.ack = ack;
        v.mt = mt; v.dty = dty; v.cd = cd; v.exp = exp;
        return v;
    endfunction

    vec_t vecs[25];

    // Sequence observation counters
    int n_dec, n_fin, n_vict, n_cdirty, n_wb_acks, n_fetch_acks, n_hv;
    int n_chit, n_cmiss, n_cread, n_cwrite, n_counts0, n_done;
    int done_cyc, pw_at_done;

    task automatic run_seq(input string name, input cache_op_t op, input logic hit,
                           input logic dty, input int k, input int rst_ack);
        int  wait_ctr = 0;
        bit  finished = 0;
        bit  rst_fired = 0;
        n_dec = 0; n_fin = 0; n_vict = 0; n_cdirty = 0; n_wb_acks = 0; n_fetch_acks = 0;
        n_hv = 0; n_chit = 0; n_cmiss = 0; n_cread = 0; n_cwrite = 0; n_counts0 = 0;
        n_done = 0; done_cyc = -1; pw_at_done = -1;

        @(negedge clk);
        reset = 1'b0; req_valid = 1'b0; hmem_req_ack = 1'b0;
        use_model = 1'b1; dirty_in = dty;
        line_set = hit; line_clear = !hit;

        for (int c = 0; c < 400 && !finished; c++) begin
            @(negedge clk);
            line_set = 1'b0; line_clear = 1'b0;
            req_valid = (c == 0);
            req_op = op;
            hmem_req_ack = 1'b0;
            if (rst_fired) begin
                reset = 1'b0;
                #1;
                check_int({name, "_hv_after_reset"}, int'(hv1), 0);
                check_int({name, "_ready_after_reset"}, int'(rdy1), 1);
                finished = 1;
            end else begin
                if (hv1) begin
                    if (wait_ctr == k - 1) begin
                        hmem_req_ack = 1'b1;
                        wait_ctr = 0;
                    end else begin
                        wait_ctr++;
                    end
                end
                if (hv1 && !hw1 && hmem_req_ack) begin
                    n_fetch_acks++;
                    if (rst_ack != 0 && n_fetch_acks == rst_ack) begin
                        reset = 1'b1;
                        rst_fired = 1;
                    end
                end
                if (hv1 && hw1 && hmem_req_ack) n_wb_acks++;
                #1;
                if (c == 0) check_int({name, "_accept_ready"}, int'(rdy1), 1);
                n_hv     += int'(hv1);
                n_dec    += int'(ci1.decrement_counter);
                n_fin    += int'(ci1.finish_new_line_install);
                n_vict   += int'(ci1.use_victim_tag_for_hmem_block_address);
                n_cdirty += int'(ci1.clear_selected_dirty_bit);
                n_chit   += int'(ci1.count_hit);
                n_cmiss  += int'(ci1.count_miss);
                n_cread  += int'(ci1.count_read);
                n_cwrite += int'(ci1.count_write);
                n_counts0 += int'(ci0.count_hit) + int'(ci0.count_miss)
                           + int'(ci0.count_read) + int'(ci0.count_write);
                n_done   += int'(done1);
                if (done1) begin
                    done_cyc = c;
                    pw_at_done = int'(ci1.perform_write);
                    finished = 1;
                end
            end
        end
        if (!finished) check_int({name, "_timeout"}, 0, 1);
        reset = 1'b0; req_valid = 1'b0; hmem_req_ack = 1'b0; use_model = 1'b0;
    endtask

    initial begin
        vecs[0]  = mk("reset",            1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_RDY);
        vecs[1]  = mk("idle_ack_ignored", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, O_RDY);
        vecs[2]  = mk("accept_rd",        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_RDY);
        vecs[3]  = mk("rd_hit",           1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
                      O_DONE | O_LRU | O_CHIT | O_CREAD);
        vecs[4]  = mk("accept_wr",        1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_RDY);
        vecs[5]  = mk("wr_hit",           1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                      O_DONE | O_LRU | O_PW | O_SD | O_CHIT | O_CWRITE);
        vecs[6]  = mk("accept_rd2",       1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_RDY);
        vecs[7]  = mk("clean_miss",       1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                      O_SADDR | O_RCNT | O_CVAL | O_CMISS | O_CREAD);
        vecs[8]  = mk("fetch_stall",      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, O_HV | O_MREC);
        vecs[9]  = mk("fetch_ack",        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                      O_HV | O_MREC | O_DEC);
        vecs[10] = mk("fetch_last",       1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
                      O_HV | O_MREC | O_DEC | O_FIN);
        vecs[11] = mk("replay_rd_hit",    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, O_DONE | O_LRU);
        vecs[12] = mk("accept_wr2",       1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_RDY);
        vecs[13] = mk("dirty_miss",       1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                      O_SADDR | O_VICT | O_RCNT | O_CMISS | O_CWRITE);
        vecs[14] = mk("wb_ack",           1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                      O_HV | O_HW | O_MREC | O_DEC);
        vecs[15] = mk("wb_stall",         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                      O_HV | O_HW | O_MREC);
        vecs[16] = mk("wb_last",          1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
                      O_HV | O_HW | O_MREC | O_DEC | O_CDIRTY | O_SADDR | O_RCNT | O_CVAL);
        vecs[17] = mk("fetch_last2",      1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
                      O_HV | O_MREC | O_DEC | O_FIN);
        vecs[18] = mk("replay_wr_hit",    1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                      O_DONE | O_LRU | O_PW | O_SD);
        vecs[19] = mk("idle_after",       1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_RDY);
        vecs[20] = mk("accept_rd3",       1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_RDY);
        vecs[21] = mk("clean_miss2",      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                      O_SADDR | O_RCNT | O_CVAL | O_CMISS | O_CREAD);
        vecs[22] = mk("fetch_rst",        1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                      O_HV | O_MREC | O_DEC);
        vecs[23] = mk("post_reset",       1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_RDY);
        vecs[24] = mk("idle_hold",        1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, O_RDY);

        reset = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            reset = vecs[i].rst; req_valid = vecs[i].vld; req_op = vecs[i].op;
            hmem_req_ack = vecs[i].ack; tbl_match = vecs[i].mt;
            dirty_in = vecs[i].dty; tbl_cdone = vecs[i].cd;
            #1;
            check_vec({vecs[i].name, "_stats1"}, obs1, vecs[i].exp);
            check_vec({vecs[i].name, "_stats0"}, obs0, vecs[i].exp & ~O_STATS);
        end

        run_seq("read_hit", OP_READ, 1'b1, 1'b0, 1, 0);
        check_int("read_hit_latency", done_cyc, 1);
        check_int("read_hit_count_hit", n_chit, 1);
        check_int("read_hit_count_read", n_cread, 1);
        check_int("read_hit_no_hmem", n_hv, 0);
        check_int("read_hit_stats_off", n_counts0, 0);

        run_seq("write_hit", OP_WRITE, 1'b1, 1'b0, 1, 0);
        check_int("write_hit_latency", done_cyc, 1);
        check_int("write_hit_perform_write", pw_at_done, 1);
        check_int("write_hit_count_write", n_cwrite, 1);

        run_seq("clean_miss", OP_READ, 1'b0, 1'b0, 1, 0);
        check_int("clean_miss_latency", done_cyc, int'(W) + 2);
        check_int("clean_miss_fetch_acks", n_fetch_acks, int'(W));
        check_int("clean_miss_wb_acks", n_wb_acks, 0);
        check_int("clean_miss_finish", n_fin, 1);
        check_int("clean_miss_count_miss", n_cmiss, 1);
        check_int("clean_miss_count_hit", n_chit, 0);
        check_int("clean_miss_count_read", n_cread, 1);
        check_int("clean_miss_decrements", n_dec, int'(W));
        check_int("clean_miss_stats_off", n_counts0, 0);

        run_seq("dirty_miss", OP_WRITE, 1'b0, 1'b1, 3, 0);
        check_int("dirty_miss_latency", done_cyc, 2 + 2 * int'(W) * 3);
        check_int("dirty_miss_victim_tag", n_vict, 1);
        check_int("dirty_miss_wb_acks", n_wb_acks, int'(W));
        check_int("dirty_miss_fetch_acks", n_fetch_acks, int'(W));
        check_int("dirty_miss_clear_dirty", n_cdirty, 1);
        check_int("dirty_miss_replay_write", pw_at_done, 1);
        check_int("dirty_miss_decrements", n_dec, 2 * int'(W));
        check_int("dirty_miss_count_miss", n_cmiss, 1);
        check_int("dirty_miss_count_write", n_cwrite, 1);
        check_int("dirty_miss_stats_off", n_counts0, 0);

        run_seq("reset_mid_fetch", OP_READ, 1'b0, 1'b0, 1, 2);
        check_int("reset_mid_fetch_no_done", n_done, 0);
        check_int("reset_mid_fetch_acks", n_fetch_acks, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_cache_controller
